avalon_sample_writer: RTL and testbench
=======================================

AVALON_SAMPLE_WRITER -- requirements
Module: avalon_sample_writer

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning sample and Avalon writedata width.
REQ-002 The block SHALL have parameter DEPTH, default 4 (power of two, >=2), meaning sample FIFO depth.
REQ-003 The block SHALL have parameter LOAD_ADDR, default 8'd0, meaning the register address that loads the integrator value.
REQ-004 The block SHALL have parameter ACC_ADDR, default 8'd1, meaning the register address that adds to the integrator value.
REQ-005 The block SHALL have one clock; reset is synchronous and active-low.
REQ-006 The block SHALL have port csi_clk  input  1  sole clock; all logic on its rising edge.
REQ-007 The block SHALL have port rsi_srst_n  input  1  synchronous active-low reset.
REQ-008 The block SHALL have port asi_in_data  input  N  upstream sample.
REQ-009 The block SHALL have port asi_in_valid  input  1  sample present.
REQ-010 The block SHALL have port asi_in_ready  output  1  block can accept a sample.
REQ-011 The block SHALL have port coe_clear  input  1  single-cycle request: the next issued write goes to LOAD_ADDR.
REQ-012 The block SHALL have port avm_m0_address  output  8  Avalon-MM master address.
REQ-013 The block SHALL have port avm_m0_write  output  1  Avalon-MM write strobe.
REQ-014 The block SHALL have port avm_m0_writedata  output  N  Avalon-MM write data.
REQ-015 The block SHALL have port avm_m0_waitrequest  input  1  slave stall.
REQ-016 The block SHALL have port coe_busy  output  1  FIFO non-empty or write in flight.
REQ-017 The block SHALL have port coe_wr_count  output  16  count of completed writes.

Function
REQ-018 A sample SHALL be accepted on an edge where asi_in_valid=1 and asi_in_ready=1; asi_in_ready SHALL equal !fifo_full (no combinational path from valid).
REQ-019 Push and pop in the same cycle SHALL leave the FIFO level unchanged; FIFO pointers SHALL wrap modulo DEPTH.
REQ-020 The FSM SHALL have states IDLE and WRITE; the Avalon outputs SHALL be registered.
REQ-021 In IDLE with the FIFO non-empty, the block SHALL pop the head and move to WRITE on the next edge, loading avm_m0_writedata=head, avm_m0_address=(first_flag ? LOAD_ADDR : ACC_ADDR) and avm_m0_write=1.
REQ-022 Latency: a sample accepted at edge k into an empty idle block SHALL appear with avm_m0_write=1 after edge k+1.
REQ-023 In WRITE, the block SHALL hold address, data and write stable while avm_m0_waitrequest=1.
REQ-024 A write SHALL complete on an edge with avm_m0_write=1 and avm_m0_waitrequest=0; on that edge coe_wr_count SHALL increment (wrapping 16'hFFFF->0).
REQ-025 On completion, if the FIFO is non-empty the block SHALL load the next sample and stay in WRITE (back-to-back, one write per cycle); otherwise it SHALL return to IDLE with avm_m0_write=0.
REQ-026 first_flag SHALL be set by reset or coe_clear=1, and cleared when a write is loaded with LOAD_ADDR.
REQ-027 coe_clear SHALL NOT alter a write already in flight; it applies to the next load.
REQ-028 If coe_clear and a load coincide on one edge, that load SHALL use LOAD_ADDR and first_flag SHALL end at 0.
REQ-029 coe_busy SHALL be high exactly when the FIFO is non-empty or the state is WRITE.

Reset
REQ-030 On an edge with rsi_srst_n=0, the block SHALL set state=IDLE, FIFO empty, first_flag=1, avm_m0_write=0, avm_m0_address=0, avm_m0_writedata=0 and coe_wr_count=0; asi_in_ready SHALL be 1 from the next cycle.
REQ-031 Reset during WRITE SHALL abandon the transaction (write low after the reset edge) and discard all buffered samples.

Structure
REQ-032 Package avalon_sample_writer_pkg SHALL hold the state enum (IDLE, WRITE) and default address constants.
REQ-033 The FIFO SHALL be a separate sub-module sync_fifo (parameters N, DEPTH; ports push, pop, din, dout, full, empty).

Verification
REQ-034 Scenario: after reset, push 55 -> one write, address 0, data 55, write high one cycle, count=1.
REQ-035 Scenario: push 55, 5, 7 back-to-back with waitrequest=0 -> writes (0,55),(1,5),(1,7) on consecutive cycles, count=3.
REQ-036 Scenario: waitrequest held high 3 cycles during (1,5) -> address and data stable 4 cycles; FIFO fills to DEPTH=4; asi_in_ready goes low, with no loss.
REQ-037 Scenario: coe_clear pulse mid-write of (1,5), then push 9 -> the in-flight write stays (1,5); the next write is (0,9).
REQ-038 Scenario: rsi_srst_n=0 during a stalled write with 3 samples buffered -> write low, busy low and count=0 after the edge; next push 12 -> write (0,12).
REQ-039 Scenario: 65537 completed writes -> coe_wr_count=1.

Source files
------------

// File: rtl/avalon_sample_writer_pkg.sv
// rtl/avalon_sample_writer_pkg.sv - shared types and constants for the sample writer
// Purpose: FSM state encoding and default register addresses used by
//          avalon_sample_writer and its bench.
package avalon_sample_writer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    localparam logic [7:0] DEF_LOAD_ADDR = 8'd0;
    localparam logic [7:0] DEF_ACC_ADDR  = 8'd1;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock sample FIFO with level counter
// Purpose: buffers upstream samples ahead of the Avalon write engine.
// Ports:
//   clk, srst_n : clock, synchronous active-low reset
//   push, din   : write request and data (ignored while full)
//   pop, dout   : read request (ignored while empty) and head-of-queue data
//   full, empty : level flags
module sync_fifo #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         srst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [N-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;

    logic w_push;
    logic w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible through the level.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_level == FULL_LEVEL);
    assign empty = (r_level == '0);

endmodule

// File: rtl/avalon_sample_writer.sv
// rtl/avalon_sample_writer.sv - streams samples into an integrator register over Avalon-MM
// Purpose: each accepted sample becomes one Avalon-MM write. The first write
//          after reset or after coe_clear goes to LOAD_ADDR, all others to ACC_ADDR.
// Ports:
//   csi_clk, rsi_srst_n        : clock, synchronous active-low reset
//   asi_in_data/valid/ready    : upstream sample stream
//   coe_clear                  : re-arm the next write to LOAD_ADDR
//   avm_m0_address/write/writedata/waitrequest : Avalon-MM master
//   coe_busy                   : FIFO non-empty or write in flight
//   coe_wr_count               : completed writes (wraps)
module avalon_sample_writer
    import avalon_sample_writer_pkg::*;
#(
    parameter int         N         = 32,
    parameter int         DEPTH     = 4,
    parameter logic [7:0] LOAD_ADDR = DEF_LOAD_ADDR,
    parameter logic [7:0] ACC_ADDR  = DEF_ACC_ADDR
) (
    input  logic         csi_clk,
    input  logic         rsi_srst_n,
    input  logic [N-1:0] asi_in_data,
    input  logic         asi_in_valid,
    output logic         asi_in_ready,
    input  logic         coe_clear,
    output logic [7:0]   avm_m0_address,
    output logic         avm_m0_write,
    output logic [N-1:0] avm_m0_writedata,
    input  logic         avm_m0_waitrequest,
    output logic         coe_busy,
    output logic [15:0]  coe_wr_count
);

    state_t r_state;
    state_t w_state_nxt;

    logic         r_first;
    logic         r_write;
    logic [7:0]   r_addr;
    logic [N-1:0] r_data;
    logic [15:0]  r_count;

    logic [N-1:0] w_fifo_dout;
    logic         w_fifo_full;
    logic         w_fifo_empty;
    logic         w_load;
    logic         w_complete;

    sync_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (csi_clk),
        .srst_n (rsi_srst_n),
        .push   (asi_in_valid),
        .pop    (w_load),
        .din    (asi_in_data),
        .dout   (w_fifo_dout),
        .full   (w_fifo_full),
        .empty  (w_fifo_empty)
    );

    always_ff @(posedge csi_clk) begin
        if (!rsi_srst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A load happens whenever the bus slot is free (idle) or is being freed
    // this edge (completion), provided a sample is waiting.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_load      = 1'b1;
                    w_state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (!avm_m0_waitrequest) begin
                    w_complete = 1'b1;
                    if (!w_fifo_empty) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge csi_clk) begin
        if (!rsi_srst_n) begin
            r_first <= 1'b1;
            r_write <= 1'b0;
            r_addr  <= 8'd0;
            r_data  <= '0;
            r_count <= 16'd0;
        end else begin
            if (w_load) begin
                r_data  <= w_fifo_dout;
                // A clear arriving on the load edge still steers this load.
                r_addr  <= (r_first || coe_clear) ? LOAD_ADDR : ACC_ADDR;
                r_write <= 1'b1;
            end else if (w_complete) begin
                r_write <= 1'b0;
            end
            // The flag is consumed by any load: either it steered the load to
            // LOAD_ADDR, or it was already clear.
            r_first <= w_load ? 1'b0 : (r_first | coe_clear);
            if (w_complete) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    assign asi_in_ready     = !w_fifo_full;
    assign avm_m0_address   = r_addr;
    assign avm_m0_write     = r_write;
    assign avm_m0_writedata = r_data;
    assign coe_busy         = !w_fifo_empty || (r_state == WRITE);
    assign coe_wr_count     = r_count;

endmodule

// File: tb/tb_avalon_sample_writer.sv
// tb/tb_avalon_sample_writer.sv - self-checking bench for avalon_sample_writer
module tb_avalon_sample_writer;

    localparam int         N     = 32;
    localparam int         DEPTH = 4;
    localparam logic [7:0] LADDR = 8'd0;
    localparam logic [7:0] AADDR = 8'd1;

    logic         csi_clk = 1'b0;
    logic         rsi_srst_n;
    logic [N-1:0] asi_in_data;
    logic         asi_in_valid;
    logic         asi_in_ready;
    logic         coe_clear;
    logic [7:0]   avm_m0_address;
    logic         avm_m0_write;
    logic [N-1:0] avm_m0_writedata;
    logic         avm_m0_waitrequest;
    logic         coe_busy;
    logic [15:0]  coe_wr_count;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of buffered samples plus one in-flight write.
    logic [N-1:0] m_q[$];
    bit           m_inf;
    bit [7:0]     m_addr;
    bit [N-1:0]   m_data;
    bit           m_first;
    bit [15:0]    m_cnt;

    always #5 csi_clk = ~csi_clk;

    avalon_sample_writer #(
        .N         (N),
        .DEPTH     (DEPTH),
        .LOAD_ADDR (LADDR),
        .ACC_ADDR  (AADDR)
    ) dut (
        .csi_clk            (csi_clk),
        .rsi_srst_n         (rsi_srst_n),
        .asi_in_data        (asi_in_data),
        .asi_in_valid       (asi_in_valid),
        .asi_in_ready       (asi_in_ready),
        .coe_clear          (coe_clear),
        .avm_m0_address     (avm_m0_address),
        .avm_m0_write       (avm_m0_write),
        .avm_m0_writedata   (avm_m0_writedata),
        .avm_m0_waitrequest (avm_m0_waitrequest),
        .coe_busy           (coe_busy),
        .coe_wr_count       (coe_wr_count)
    );

    // Advance the model by one edge using the currently driven inputs, then
    // let the DUT take the same edge and settle.
    task automatic step();
        bit acc, comp, ld;
        if (!rsi_srst_n) begin
            m_q.delete();
            m_inf = 0; m_addr = 0; m_data = 0; m_first = 1; m_cnt = 0;
        end else begin
            acc  = asi_in_valid && (m_q.size() < DEPTH);
            comp = m_inf && !avm_m0_waitrequest;
            ld   = (m_q.size() > 0) && (!m_inf || comp);
            if (comp) m_cnt++;
            if (ld) begin
                m_data  = m_q.pop_front();
                m_addr  = (m_first || coe_clear) ? LADDR : AADDR;
                m_inf   = 1;
                m_first = 0;
            end else begin
                if (comp) m_inf = 0;
                if (coe_clear) m_first = 1;
            end
            if (acc) m_q.push_back(asi_in_data);
        end
        @(posedge csi_clk);
        #1;
    endtask

    task automatic reset_dut();
        rsi_srst_n = 0; asi_in_valid = 0; asi_in_data = 0;
        coe_clear = 0; avm_m0_waitrequest = 0;
        step();
        rsi_srst_n = 1;
    endtask

    task automatic test_reset();
        reset_dut();
        total++; if (avm_m0_write !== 1'b0) begin bad++; $display("FAIL reset_write got=%0b exp=0", avm_m0_write); end
        total++; if (avm_m0_address !== 8'd0) begin bad++; $display("FAIL reset_addr got=%0h exp=0", avm_m0_address); end
        total++; if (avm_m0_writedata !== '0) begin bad++; $display("FAIL reset_data got=%0h exp=0", avm_m0_writedata); end
        total++; if (coe_wr_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", coe_wr_count); end
        total++; if (coe_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", coe_busy); end
        total++; if (asi_in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", asi_in_ready); end
    endtask

    task automatic test_single();
        int nwr = 0;
        int first_cyc = -1;
        reset_dut();
        asi_in_valid = 1; asi_in_data = 55;
        step();
        asi_in_valid = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (avm_m0_write === 1'b1) begin
                nwr++;
                if (first_cyc < 0) first_cyc = c;
                total++;
                if (avm_m0_address !== 8'd0 || avm_m0_writedata !== 32'd55) begin
                    bad++; $display("FAIL single_wr got=(%0h,%0d) exp=(0,55)", avm_m0_address, avm_m0_writedata);
                end
            end
        end
        total++; if (nwr != 1) begin bad++; $display("FAIL single_cycles got=%0d exp=1", nwr); end
        total++; if (first_cyc != 0) begin bad++; $display("FAIL single_latency got=%0d exp=0", first_cyc); end
        total++; if (coe_wr_count !== 16'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", coe_wr_count); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] s[3] = '{55, 5, 7};
        logic [39:0]  exp[3] = '{{8'd0, 32'd55}, {8'd1, 32'd5}, {8'd1, 32'd7}};
        logic [39:0]  got[$];
        int           cyc[$];
        reset_dut();
        for (int c = 0; c < 9; c++) begin
            asi_in_valid = (c < 3);
            asi_in_data  = (c < 3) ? s[c] : '0;
            if (avm_m0_write && !avm_m0_waitrequest) begin
                got.push_back({avm_m0_address, avm_m0_writedata});
                cyc.push_back(c);
            end
            step();
            total++;
            if (avm_m0_write !== m_inf || (m_inf && {avm_m0_address, avm_m0_writedata} !== {m_addr, m_data})) begin
                bad++; $display("FAIL b2b_model c=%0d got=(%0b,%0h,%0h) exp=(%0b,%0h,%0h)", c,
                    avm_m0_write, avm_m0_address, avm_m0_writedata, m_inf, m_addr, m_data);
            end
        end
        total++; if (got.size() != 3) begin bad++; $display("FAIL b2b_nwrites got=%0d exp=3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL b2b_wr%0d got=%0h exp=%0h", i, got[i], exp[i]); end
        end
        if (got.size() == 3) begin
            total++; if (cyc[2] - cyc[0] != 2) begin bad++; $display("FAIL b2b_consecutive got=%0d exp=2", cyc[2] - cyc[0]); end
        end
        total++; if (coe_wr_count !== 16'd3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", coe_wr_count); end
    endtask

    task automatic test_stall();
        logic [N-1:0] s[7] = '{55, 5, 10, 11, 12, 13, 14};
        logic [N-1:0] got[$];
        int idx = 0, stalls = 0, seen5 = 0;
        bit not_ready = 0, acc;
        reset_dut();
        for (int c = 0; c < 30; c++) begin
            asi_in_valid = (idx < 7);
            asi_in_data  = (idx < 7) ? s[idx] : '0;
            avm_m0_waitrequest = 0;
            if (avm_m0_write && avm_m0_address == 8'd1 && avm_m0_writedata == 32'd5) begin
                seen5++;
                if (stalls < 3) begin avm_m0_waitrequest = 1; stalls++; end
            end
            if (!asi_in_ready) not_ready = 1;
            if (avm_m0_write && !avm_m0_waitrequest) got.push_back(avm_m0_writedata);
            acc = asi_in_valid && asi_in_ready;
            step();
            if (acc) idx++;
            total++;
            if (avm_m0_write !== m_inf || asi_in_ready !== (m_q.size() < DEPTH) ||
                (m_inf && {avm_m0_address, avm_m0_writedata} !== {m_addr, m_data})) begin
                bad++; $display("FAIL stall_model c=%0d got=(%0b,%0b,%0h,%0h) exp=(%0b,%0b,%0h,%0h)", c,
                    avm_m0_write, asi_in_ready, avm_m0_address, avm_m0_writedata,
                    m_inf, (m_q.size() < DEPTH), m_addr, m_data);
            end
        end
        avm_m0_waitrequest = 0;
        total++; if (seen5 != 4) begin bad++; $display("FAIL stall_hold got=%0d exp=4", seen5); end
        total++; if (!not_ready) begin bad++; $display("FAIL stall_ready_low got=0 exp=1"); end
        total++; if (got.size() != 7) begin bad++; $display("FAIL stall_nwrites got=%0d exp=7", got.size()); end
        for (int i = 0; i < 7 && i < got.size(); i++) begin
            total++; if (got[i] !== s[i]) begin bad++; $display("FAIL stall_data%0d got=%0d exp=%0d", i, got[i], s[i]); end
        end
        total++; if (coe_wr_count !== 16'd7) begin bad++; $display("FAIL stall_count got=%0d exp=7", coe_wr_count); end
    endtask

    task automatic test_clear();
        logic [39:0] exp[3] = '{{8'd0, 32'd55}, {8'd1, 32'd5}, {8'd0, 32'd9}};
        logic [39:0] got[$];
        int idx = 0, stall = 0, n5 = 0;
        bit cleared = 0, acc;
        reset_dut();
        for (int c = 0; c < 14; c++) begin
            asi_in_valid = 0; coe_clear = 0; avm_m0_waitrequest = 0;
            if (idx < 2) begin
                asi_in_valid = 1; asi_in_data = (idx == 0) ? 32'd55 : 32'd5;
            end else if (cleared && idx == 2) begin
                asi_in_valid = 1; asi_in_data = 32'd9;
            end
            if (avm_m0_write && avm_m0_address == 8'd1 && avm_m0_writedata == 32'd5) begin
                n5++;
                if (stall < 2) begin avm_m0_waitrequest = 1; stall++; end
                if (!cleared) begin coe_clear = 1; cleared = 1; end
            end
            if (avm_m0_write && !avm_m0_waitrequest) got.push_back({avm_m0_address, avm_m0_writedata});
            acc = asi_in_valid && asi_in_ready;
            step();
            if (acc) idx++;
            total++;
            if (avm_m0_write !== m_inf || (m_inf && {avm_m0_address, avm_m0_writedata} !== {m_addr, m_data})) begin
                bad++; $display("FAIL clear_model c=%0d got=(%0b,%0h,%0h) exp=(%0b,%0h,%0h)", c,
                    avm_m0_write, avm_m0_address, avm_m0_writedata, m_inf, m_addr, m_data);
            end
        end
        coe_clear = 0;
        total++; if (n5 != 3) begin bad++; $display("FAIL clear_inflight_hold got=%0d exp=3", n5); end
        total++; if (got.size() != 3) begin bad++; $display("FAIL clear_nwrites got=%0d exp=3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL clear_wr%0d got=%0h exp=%0h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_reset_midwrite();
        logic [N-1:0] s[4] = '{55, 5, 6, 7};
        int nwr = 0;
        reset_dut();
        asi_in_valid = 1; asi_in_data = 1;
        step();
        asi_in_valid = 0;
        repeat (3) step();
        avm_m0_waitrequest = 1;
        for (int i = 0; i < 4; i++) begin
            asi_in_valid = 1; asi_in_data = s[i];
            step();
        end
        asi_in_valid = 0;
        step();
        total++; if (avm_m0_write !== 1'b1 || coe_busy !== 1'b1 || coe_wr_count !== 16'd1) begin
            bad++; $display("FAIL rstmid_pre got=(%0b,%0b,%0d) exp=(1,1,1)", avm_m0_write, coe_busy, coe_wr_count);
        end
        rsi_srst_n = 0;
        step();
        rsi_srst_n = 1;
        total++; if (avm_m0_write !== 1'b0) begin bad++; $display("FAIL rstmid_write got=%0b exp=0", avm_m0_write); end
        total++; if (coe_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%0b exp=0", coe_busy); end
        total++; if (coe_wr_count !== 16'd0) begin bad++; $display("FAIL rstmid_count got=%0d exp=0", coe_wr_count); end
        total++; if (asi_in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%0b exp=1", asi_in_ready); end
        avm_m0_waitrequest = 0;
        asi_in_valid = 1; asi_in_data = 12;
        step();
        asi_in_valid = 0;
        for (int c = 0; c < 5; c++) begin
            if (avm_m0_write) begin
                nwr++;
                total++;
                if (avm_m0_address !== 8'd0 || avm_m0_writedata !== 32'd12) begin
                    bad++; $display("FAIL rstmid_wr got=(%0h,%0d) exp=(0,12)", avm_m0_address, avm_m0_writedata);
                end
            end
            step();
        end
        total++; if (nwr != 1) begin bad++; $display("FAIL rstmid_nwrites got=%0d exp=1", nwr); end
        total++; if (coe_wr_count !== 16'd1) begin bad++; $display("FAIL rstmid_count2 got=%0d exp=1", coe_wr_count); end
    endtask

    task automatic test_random();
        reset_dut();
        for (int c = 0; c < 400; c++) begin
            asi_in_valid       = ($urandom_range(0, 99) < 60);
            asi_in_data        = $urandom;
            avm_m0_waitrequest = ($urandom_range(0, 99) < 30);
            coe_clear          = ($urandom_range(0, 99) < 6);
            step();
            total++;
            if (avm_m0_write !== m_inf || asi_in_ready !== (m_q.size() < DEPTH) ||
                coe_busy !== (m_inf || m_q.size() > 0) || coe_wr_count !== m_cnt ||
                (m_inf && {avm_m0_address, avm_m0_writedata} !== {m_addr, m_data})) begin
                bad++; $display("FAIL random c=%0d got=(%0b,%0b,%0b,%0d,%0h,%0h) exp=(%0b,%0b,%0b,%0d,%0h,%0h)", c,
                    avm_m0_write, asi_in_ready, coe_busy, coe_wr_count, avm_m0_address, avm_m0_writedata,
                    m_inf, (m_q.size() < DEPTH), (m_inf || m_q.size() > 0), m_cnt, m_addr, m_data);
            end
        end
        asi_in_valid = 0; coe_clear = 0; avm_m0_waitrequest = 0;
    endtask

    task automatic test_count_wrap();
        int done = 0;
        reset_dut();
        asi_in_valid = 1;
        for (int c = 0; c < 70000 && done < 65537; c++) begin
            asi_in_data = $urandom;
            if (avm_m0_write && !avm_m0_waitrequest) done++;
            if (done < 65537) begin
                step();
                if ((c % 1024) == 0) begin
                    total++;
                    if (coe_wr_count !== m_cnt) begin
                        bad++; $display("FAIL wrap_track c=%0d got=%0d exp=%0d", c, coe_wr_count, m_cnt);
                    end
                end
            end
        end
        asi_in_valid = 0;
        step();
        total++; if (done != 65537) begin bad++; $display("FAIL wrap_timeout got=%0d exp=65537", done); end
        total++; if (coe_wr_count !== 16'd1) begin bad++; $display("FAIL wrap_count got=%0d exp=1", coe_wr_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_clear();
        test_reset_midwrite();
        test_random();
        test_count_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
